// File: rtl/bus_master_rr.sv
`default_nettype none
// ============================================================================
// Module   : bus_master_rr
// Purpose  : Round-robin bus master. Collects level requests from N_CH
//            channels and grants one channel at a time. It latches that
//            channel's data word and drives it on a tri-stated bus until the
//            target acknowledges or a timeout expires. Each transfer ends with
//            a one-cycle RELEASE gap before the next grant.
// Ports    : clk       - clock, rising edge
//            reset     - synchronous active-high reset
//            req_in    - per-channel request levels
//            data_in   - packed channel words, channel i at [i*DATA_W +: DATA_W]
//            bus_ack   - target acknowledge (only looked at while waiting)
//            bus_req   - registered bus request
//            bus_data  - held word while bus_oe=1, high-Z otherwise
//            bus_oe    - registered bus drive enable
//            grant_id  - channel owning the current transfer, 0 when idle
//            ch_done   - one-cycle per-channel acknowledge pulse
//            ch_err    - one-cycle per-channel timeout pulse
//            busy      - high whenever the master is not idle
// Revision : 1.0 - initial release
// ============================================================================
module bus_master_rr #(
  parameter int DATA_W  = 8,
  parameter int N_CH    = 4,
  parameter int TIMEOUT = 15
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [N_CH-1:0]            req_in,
  input  logic [N_CH*DATA_W-1:0]     data_in,
  input  logic                       bus_ack,
  output logic                       bus_req,
  output logic [DATA_W-1:0]          bus_data,
  output logic                       bus_oe,
  output logic [$clog2(N_CH)-1:0]    grant_id,
  output logic [N_CH-1:0]            ch_done,
  output logic [N_CH-1:0]            ch_err,
  output logic                       busy
);

  localparam int GW = $clog2(N_CH);
  localparam int CW = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_WAIT    = 2'd1,
    S_RELEASE = 2'd2
  } state_e;

  state_e              state_q;
  logic [DATA_W-1:0]   hold_q;
  logic [GW-1:0]       grant_q;
  logic [GW-1:0]       last_q;
  logic [CW-1:0]       cnt_q;
  logic [N_CH-1:0]     done_q;
  logic [N_CH-1:0]     err_q;
  logic                req_q;
  logic                oe_q;

  logic [GW-1:0]       pick_d;
  logic [DATA_W-1:0]   word_d;
  logic [GW:0]         rr_sum;
  logic [GW-1:0]       rr_idx;

  // Round-robin pick: offsets are scanned from farthest to nearest so the
  // nearest requester after last_q overwrites the others and wins. The sum
  // is one bit wider so the wrap past N_CH-1 can be undone by a subtract,
  // which keeps non-power-of-two channel counts correct.
  always_comb begin
    pick_d = '0;
    rr_sum = '0;
    rr_idx = '0;
    for (int off = N_CH; off >= 1; off--) begin
      rr_sum = {1'b0, last_q} + (GW+1)'(off);
      rr_idx = (rr_sum >= (GW+1)'(N_CH)) ? GW'(rr_sum - (GW+1)'(N_CH))
                                         : rr_sum[GW-1:0];
      if (req_in[rr_idx]) pick_d = rr_idx;
    end
  end

  // Word of the channel about to be granted.
  always_comb begin
    word_d = '0;
    for (int i = 0; i < N_CH; i++) begin
      if (GW'(i) == pick_d) word_d = data_in[i*DATA_W +: DATA_W];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      hold_q  <= '0;
      grant_q <= '0;
      last_q  <= GW'(N_CH - 1);   // channel 0 wins the first arbitration
      cnt_q   <= '0;
      done_q  <= '0;
      err_q   <= '0;
      req_q   <= 1'b0;
      oe_q    <= 1'b0;
    end else begin
      // Completion flags are single-cycle pulses.
      done_q <= '0;
      err_q  <= '0;
      case (state_q)
        S_IDLE: begin
          if (|req_in) begin
            hold_q  <= word_d;
            grant_q <= pick_d;
            last_q  <= pick_d;
            cnt_q   <= '0;
            req_q   <= 1'b1;
            oe_q    <= 1'b1;
            state_q <= S_WAIT;
          end
        end
        S_WAIT: begin
          // An acknowledge on the last allowed cycle still counts as success.
          if (bus_ack) begin
            done_q[grant_q] <= 1'b1;
            req_q           <= 1'b0;
            oe_q            <= 1'b0;
            state_q         <= S_RELEASE;
          end else if (cnt_q == CNT_LAST) begin
            err_q[grant_q]  <= 1'b1;
            req_q           <= 1'b0;
            oe_q            <= 1'b0;
            state_q         <= S_RELEASE;
          end else begin
            cnt_q <= cnt_q + CW'(1);
          end
        end
        S_RELEASE: begin
          // One dead cycle lets the finished requester drop its request
          // before arbitration runs again.
          grant_q <= '0;
          state_q <= S_IDLE;
        end
        default: begin
          state_q <= S_IDLE;
          req_q   <= 1'b0;
          oe_q    <= 1'b0;
          grant_q <= '0;
        end
      endcase
    end
  end

  assign bus_req  = req_q;
  assign bus_oe   = oe_q;
  assign bus_data = oe_q ? hold_q : {DATA_W{1'bz}};
  assign grant_id = grant_q;
  assign ch_done  = done_q;
  assign ch_err   = err_q;
  assign busy     = (state_q != S_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_bus_master_rr.sv
`default_nettype none
// ============================================================================
// Module   : tb_bus_master_rr
// Purpose  : Directed self-checking bench for bus_master_rr (DATA_W=8,
//            N_CH=4, TIMEOUT=15). Inputs change 1 ns after a rising edge and
//            outputs are checked at that same point, so every check sees the
//            state produced by the edge just passed.
// Revision : 1.0 - initial release
// ============================================================================
module tb_bus_master_rr;

  logic        clk;
  logic        reset;
  logic [3:0]  req_in;
  logic [31:0] data_in;
  logic        bus_ack;
  logic        bus_req;
  wire  [7:0]  bus_data;
  logic        bus_oe;
  logic [1:0]  grant_id;
  logic [3:0]  ch_done;
  logic [3:0]  ch_err;
  logic        busy;

  int n_cmp  = 0;
  int n_fail = 0;

  bus_master_rr #(
    .DATA_W  (8),
    .N_CH    (4),
    .TIMEOUT (15)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .req_in   (req_in),
    .data_in  (data_in),
    .bus_ack  (bus_ack),
    .bus_req  (bus_req),
    .bus_data (bus_data),
    .bus_oe   (bus_oe),
    .grant_id (grant_id),
    .ch_done  (ch_done),
    .ch_err   (ch_err),
    .busy     (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp)
      else begin
        n_fail++;
        $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
  endtask

  // Checks the complete idle output state.
  task automatic chk_idle(input string tag);
    chk({tag, ".bus_req"},  32'(bus_req),  32'd0);
    chk({tag, ".bus_oe"},   32'(bus_oe),   32'd0);
    chk({tag, ".grant_id"}, 32'(grant_id), 32'd0);
    chk({tag, ".ch_done"},  32'(ch_done),  32'd0);
    chk({tag, ".ch_err"},   32'(ch_err),   32'd0);
    chk({tag, ".busy"},     32'(busy),     32'd0);
  endtask

  logic [1:0] rr_exp [5];
  logic [7:0] rr_word [4];

  initial begin
    rr_exp  = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
    rr_word = '{8'h10, 8'h21, 8'h32, 8'h43};

    reset   = 1'b1;
    req_in  = 4'b0000;
    data_in = 32'h0;
    bus_ack = 1'b0;
    step();
    step();
    chk_idle("reset");
    reset = 1'b0;

    // Acknowledge while idle is ignored.
    bus_ack = 1'b1;
    step();
    chk_idle("idle_ack");
    bus_ack = 1'b0;

    // Single transfer on channel 0, acknowledged two cycles after bus_req.
    data_in[7:0] = 8'hA5;
    req_in       = 4'b0001;
    step();
    chk("t1.bus_req",  32'(bus_req),  32'd1);
    chk("t1.bus_oe",   32'(bus_oe),   32'd1);
    chk("t1.bus_data", 32'(bus_data), 32'hA5);
    chk("t1.grant",    32'(grant_id), 32'd0);
    chk("t1.busy",     32'(busy),     32'd1);
    step();
    chk("t1.wait2_done", 32'(ch_done), 32'd0);
    bus_ack = 1'b1;
    step();
    chk("t1.done",     32'(ch_done), 32'b0001);
    chk("t1.err",      32'(ch_err),  32'd0);
    chk("t1.rel_oe",   32'(bus_oe),  32'd0);
    chk("t1.rel_req",  32'(bus_req), 32'd0);
    chk("t1.rel_busy", 32'(busy),    32'd1);
    bus_ack = 1'b0;
    req_in  = 4'b0000;
    step();
    chk_idle("t1.idle");

    // Round robin with all four channels requesting; reset first so that
    // channel 0 leads. A finished requester drops for one cycle, then rejoins.
    reset = 1'b1;
    step();
    reset   = 1'b0;
    data_in = {rr_word[3], rr_word[2], rr_word[1], rr_word[0]};
    req_in  = 4'b1111;
    for (int g = 0; g < 5; g++) begin
      step();
      chk($sformatf("rr%0d.grant", g), 32'(grant_id), 32'(rr_exp[g]));
      chk($sformatf("rr%0d.data", g),  32'(bus_data), 32'(rr_word[rr_exp[g]]));
      bus_ack = 1'b1;
      step();
      chk($sformatf("rr%0d.done", g), 32'(ch_done), 32'(4'b0001 << rr_exp[g]));
      bus_ack = 1'b0;
      req_in[rr_exp[g]] = 1'b0;
      step();
      req_in[rr_exp[g]] = 1'b1;
    end
    req_in = 4'b0000;
    step();
    chk_idle("rr.idle");

    // Timeout on channel 2: last grant was 0, so channel 2 is next.
    req_in = 4'b0100;
    step();
    chk("to.grant", 32'(grant_id), 32'd2);
    for (int c = 1; c < 15; c++) begin
      step();
      chk($sformatf("to.wait%0d.err", c), 32'(ch_err), 32'd0);
    end
    chk("to.still_oe", 32'(bus_oe), 32'd1);
    step();
    chk("to.err",  32'(ch_err),  32'b0100);
    chk("to.done", 32'(ch_done), 32'd0);
    chk("to.oe",   32'(bus_oe),  32'd0);
    req_in = 4'b0000;
    step();
    chk_idle("to.idle");

    // Acknowledge on the 15th waiting cycle counts as success (channel 1).
    req_in = 4'b0010;
    step();
    chk("late.grant", 32'(grant_id), 32'd1);
    for (int c = 1; c < 15; c++) step();
    chk("late.no_err_yet", 32'(ch_err), 32'd0);
    bus_ack = 1'b1;
    step();
    chk("late.done", 32'(ch_done), 32'b0010);
    chk("late.err",  32'(ch_err),  32'd0);
    bus_ack = 1'b0;
    req_in  = 4'b0000;
    step();
    chk("late.idle_err", 32'(ch_err), 32'd0);
    chk_idle("late.idle");

    // Held word survives a change of data_in during the wait (channel 2).
    data_in[23:16] = 8'h5A;
    req_in         = 4'b0100;
    step();
    chk("hold.grant", 32'(grant_id), 32'd2);
    chk("hold.data0", 32'(bus_data), 32'h5A);
    data_in[23:16] = 8'hC3;
    step();
    chk("hold.data1", 32'(bus_data), 32'h5A);
    step();
    chk("hold.data2", 32'(bus_data), 32'h5A);
    bus_ack = 1'b1;
    step();
    chk("hold.done", 32'(ch_done), 32'b0100);
    chk("hold.oe",   32'(bus_oe),  32'd0);
    bus_ack = 1'b0;
    req_in  = 4'b0000;
    step();

    // Reset on the third waiting cycle of channel 1 aborts silently, even
    // with an acknowledge present; afterwards channel 0 wins again.
    data_in[7:0] = 8'h3C;
    req_in       = 4'b0010;
    step();
    chk("abort.grant", 32'(grant_id), 32'd1);
    step();
    step();
    reset   = 1'b1;
    bus_ack = 1'b1;
    step();
    chk_idle("abort.reset");
    reset   = 1'b0;
    bus_ack = 1'b0;
    req_in  = 4'b0011;
    step();
    chk("abort.regrant", 32'(grant_id), 32'd0);
    chk("abort.data",    32'(bus_data), 32'h3C);
    bus_ack = 1'b1;
    step();
    chk("abort.done", 32'(ch_done), 32'b0001);
    bus_ack = 1'b0;
    req_in  = 4'b0000;
    step();
    step();
    chk_idle("final");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
